// File: rtl/ram_stream_reader_if.sv
// ram_stream_reader_if: command, RAM read port and output stream bundle for the RAM stream reader
interface ram_stream_reader_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
);
   logic                  start;
   logic [ADDR_WIDTH-1:0] base;
   logic [ADDR_WIDTH:0]   count;
   logic [ADDR_WIDTH-1:0] raddr;
   logic [DATA_WIDTH-1:0] rdata;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_valid;
   logic                  m_ready;
   logic                  m_last;
   logic                  busy;
   logic                  done;
   modport master (
      input  start, base, count, rdata, m_ready,
      output raddr, m_data, m_valid, m_last, busy, done
   );
   modport slave (
      output start, base, count, rdata, m_ready,
      input  raddr, m_data, m_valid, m_last, busy, done
   );
endinterface

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: issues RAM reads for a command and streams the words out through a 2-entry skid FIFO
module ram_stream_reader #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input logic clk,
   input logic rst,
   ram_stream_reader_if.master bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [ADDR_WIDTH:0] ONE = 1;
   logic [1:0]            state;
   logic [ADDR_WIDTH:0]   iss_cnt, del_cnt;
   logic                  inflight;
   logic [DATA_WIDTH-1:0] fifo [2];
   logic                  wp, rp;
   logic [1:0]            occ, occ_next;
   logic                  pop, issue;
   assign pop          = bus.m_valid & bus.m_ready;
   assign occ_next     = occ + {1'b0, inflight} - {1'b0, pop};
   // a read issued now lands in the FIFO one cycle later, so it needs a free slot then
   assign issue        = state == RUN && occ_next < 2'd2;
   assign bus.m_valid  = occ != 2'd0;
   assign bus.m_data   = fifo[rp];
   assign bus.m_last   = bus.m_valid && del_cnt == ONE;
   assign bus.busy     = state != IDLE;
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         bus.raddr <= '0;
         bus.done  <= 1'b0;
         iss_cnt   <= '0;
         del_cnt   <= '0;
         inflight  <= 1'b0;
         fifo      <= '{default: '0};
         wp        <= 1'b0;
         rp        <= 1'b0;
         occ       <= 2'd0;
      end else begin
         bus.done <= 1'b0;
         inflight <= issue;
         occ      <= occ_next;
         if (inflight) begin
            fifo[wp] <= bus.rdata;
            wp       <= ~wp;
         end
         if (pop) begin
            rp      <= ~rp;
            del_cnt <= del_cnt - 1'b1;
         end
         case (state)
            IDLE: if (bus.start) begin
               if (bus.count != '0) begin
                  bus.raddr <= bus.base;
                  iss_cnt   <= bus.count;
                  del_cnt   <= bus.count;
                  state     <= RUN;
               end else bus.done <= 1'b1;
            end
            RUN: if (issue) begin
               bus.raddr <= bus.raddr + 1'b1;
               iss_cnt   <= iss_cnt - 1'b1;
               if (iss_cnt == ONE) state <= DRAIN;
            end
            DRAIN: if (pop && del_cnt == ONE) begin
               state    <= IDLE;
               bus.done <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
